// File: rtl/cube_pkg.sv
// Shared types and constants for the cube block.
package cube_pkg;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned MUL_CYCLES = 16;
  localparam int unsigned OVF_LIMIT  = 40;

  // Control states: square pass, cube pass, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    CU   = 2'd2,
    DONE = 2'd3
  } state_e;

  // True x^3 exceeds the 16-bit range exactly when x > 40 (40^3 = 64000, 41^3 = 68921).
  function automatic logic over_limit(input logic [WIDTH-1:0] x);
    return x > WIDTH'(OVF_LIMIT);
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per clock.
// The start edge loads the operands and retires bit 0; bits 1..15 follow on the
// next 15 edges, so a multiply occupies exactly MUL_CYCLES clocks. done pulses
// for one cycle right after the last iteration, with p already final.
module mul_shift_add
  import cube_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               done
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               done_q, done_d;

  // Operand, accumulator and iteration-count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  // Load-and-first-iteration on start, otherwise one shift-add step per clock.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start) begin
      // A new start wins over any multiply still in flight.
      mcand_d  = {{WIDTH{1'b0}}, a} << 1;
      mplier_d = b >> 1;
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      cnt_d    = CNT_W'(1);
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign p    = acc_q;
  assign done = done_q;

endmodule

// File: rtl/cube.sv
// Computes x^3 mod 2^16 with a single shared shift-add multiplier:
// first x*x, then (x*x mod 2^16)*x. Fixed latency independent of the operand.
module cube
  import cube_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  output logic [WIDTH-1:0] y_out,
  output logic             ready,
  output logic             busy,
  output logic             ovf
);

  state_e state_q, state_d;

  logic             accept;
  logic             finish;
  logic [WIDTH-1:0] x_q;
  logic             launch_q;
  logic [WIDTH-1:0] y_q;
  logic             ovf_q;

  logic               mul_start;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_p;
  logic               mul_done;
  logic               unused_p_hi;

  // Requests are only looked at while idle; anything arriving while busy is dropped.
  assign accept = (state_q == IDLE) && start;
  assign finish = (state_q == CU) && mul_done;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = SQ;
      SQ:      if (mul_done) state_d = CU;
      CU:      if (mul_done) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Outputs decoded from state: ready only in DONE, busy through both multiply passes.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    unique case (state_q)
      IDLE:    ;
      SQ:      busy  = 1'b1;
      CU:      busy  = 1'b1;
      DONE:    ready = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, first-launch flag and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q      <= '0;
      launch_q <= 1'b0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      launch_q <= accept;
      if (accept) begin
        x_q <= x_in;
      end
      // Results change only on the completion edge and hold until the next one.
      if (finish) begin
        y_q   <= mul_p[WIDTH-1:0];
        ovf_q <= over_limit(x_q);
      end
    end
  end

  // Multiplier sequencing: the square pass starts the clock after acceptance from
  // the latched operand; the cube pass starts on the square's done pulse, feeding
  // the low half of the square straight back in (the multiplier keeps its copy).
  always_comb begin
    mul_start = 1'b0;
    mul_a     = x_q;
    mul_b     = x_q;
    if (launch_q) begin
      mul_start = 1'b1;
    end else if ((state_q == SQ) && mul_done) begin
      mul_start = 1'b1;
      mul_a     = mul_p[WIDTH-1:0];
    end
  end

  mul_shift_add u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .p     (mul_p),
    .done  (mul_done)
  );

  // Result is mod 2^16, so the upper product half is deliberately dropped.
  assign unused_p_hi = ^mul_p[2*WIDTH-1:WIDTH];

  assign y_out = y_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_cube.sv
// Directed bench for cube: fixed-latency results, ignored requests, reset abort
// and back-to-back operation, all against hand-computed values.
module tb_cube;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] x_in;
  logic [15:0] y_out;
  logic        ready;
  logic        busy;
  logic        ovf;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  cube dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x_in  (x_in),
    .y_out (y_out),
    .ready (ready),
    .busy  (busy),
    .ovf   (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One operation from idle. Latency counts the accepting edge as clock 1.
  // poke_a/poke_b: clock numbers at which start is raised again while busy.
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] exp_y,
                        input logic exp_ovf, input int poke_a, input int poke_b);
    int          lat;
    int          busy_gaps;
    int          y_moves;
    logic [15:0] y_prev;
    logic        ovf_prev;
    @(negedge clk);
    x_in     = x;
    start    = 1'b1;
    y_prev   = y_out;
    ovf_prev = ovf;
    busy_gaps = 0;
    y_moves   = 0;
    @(posedge clk);
    lat = 1;
    while (lat < 100) begin
      @(negedge clk);
      if (ready) break;
      if (!busy) busy_gaps++;
      if (y_out !== y_prev || ovf !== ovf_prev) y_moves++;
      // Operand must already be latched; scramble the input.
      x_in  = x + 16'd4;
      start = (lat + 1 == poke_a) || (lat + 1 == poke_b);
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, lat, 34);
    check({tag, " busy gaps"}, busy_gaps, 0);
    check({tag, " early y/ovf change"}, y_moves, 0);
    check({tag, " y_out"}, y_out, exp_y);
    check({tag, " ovf"}, ovf, exp_ovf);
    check({tag, " busy at ready"}, busy, 0);
    @(negedge clk);
    check({tag, " ready one cycle"}, ready, 0);
    check({tag, " busy after"}, busy, 0);
    check({tag, " y_out held"}, y_out, exp_y);
  endtask

  initial begin
    int extra;
    int rise[$];
    int bad;
    int cyc;
    int d1;
    int d2;

    rst   = 1'b0;
    start = 1'b0;
    x_in  = 16'd0;
    #12;
    check("reset y_out", y_out, 0);
    check("reset ready", ready, 0);
    check("reset busy", busy, 0);
    check("reset ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle busy", busy, 0);

    run_op("x3", 16'd3, 16'd27, 1'b0, 0, 0);
    run_op("x40", 16'd40, 16'd64000, 1'b0, 0, 0);
    run_op("x41", 16'd41, 16'd3385, 1'b1, 0, 0);
    run_op("x65535", 16'd65535, 16'd65535, 1'b1, 0, 0);
    run_op("x0", 16'd0, 16'd0, 1'b0, 0, 0);

    // Requests at clocks 5 and 20 land while busy: neither queues nor disturbs.
    run_op("x5 pokes", 16'd5, 16'd125, 1'b0, 5, 20);
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (ready || busy) extra++;
    end
    check("x5 no queued op", extra, 0);

    // Reset at clock 20 of an x=7 operation.
    @(negedge clk);
    x_in  = 16'd7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort y_out", y_out, 0);
    check("abort busy", busy, 0);
    check("abort ready", ready, 0);
    check("abort ovf", ovf, 0);
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready || busy) extra++;
    end
    check("abort no ready/busy", extra, 0);
    run_op("x2 after reset", 16'd2, 16'd8, 1'b0, 0, 0);

    // start held high: one operation every 35 clocks.
    @(negedge clk);
    x_in  = 16'd4;
    start = 1'b1;
    bad   = 0;
    cyc   = 0;
    while (rise.size() < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ready) rise.push_back(cyc);
      if (rise.size() > 0 && (y_out !== 16'd64 || ovf !== 1'b0)) bad++;
    end
    start = 1'b0;
    check("b2b pulse count", rise.size(), 3);
    d1 = (rise.size() == 3) ? rise[1] - rise[0] : -1;
    d2 = (rise.size() == 3) ? rise[2] - rise[1] : -1;
    check("b2b period 1", d1, 35);
    check("b2b period 2", d2, 35);
    check("b2b y/ovf stable", bad, 0);
    repeat (3) @(negedge clk);
    check("b2b idle after", busy, 0);
    check("b2b final y_out", y_out, 64);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cube.md
CUBE -- requirements
Module: cube

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  request; sampled only while idle.
REQ-004 x_in  input  16  unsigned operand; sampled on the accepting edge.
REQ-005 y_out  output  16  x^3 mod 2^16; holds last result until next completion.
REQ-006 ready  output  1  one-cycle completion pulse; y_out and ovf are valid while high.
REQ-007 busy  output  1  high from the accepting edge until the edge that raises ready.
REQ-008 ovf  output  1  high when the true x^3 exceeds 65535 (x_in > 40); updated together with y_out.

Function
REQ-009 The block SHALL implement the states IDLE, SQ, CU and DONE.
REQ-010 The block SHALL leave IDLE for SQ only on an edge where start=1.
  - On that edge it SHALL latch x_in, assert busy and launch multiply x*x.
REQ-011 The block SHALL use one shared sequential shift-add multiplier.
  - 16x16 -> 32 bits, one bit per clock, exactly 16 clocks per multiply.
REQ-012 SQ: when the multiply completes, the block SHALL keep sq[15:0] and launch sq[15:0]*x, then move to CU.
REQ-013 CU: when the multiply completes, the block SHALL move to DONE.
  - On that edge it SHALL write y_out = product[15:0] and ovf = (x > 40).
REQ-014 DONE: the block SHALL assert ready for exactly one cycle, deassert busy and return to IDLE on the next edge.
REQ-015 Latency SHALL be fixed: ready goes high exactly 34 clocks after the accepting edge, for every x_in.
REQ-016 start SHALL be ignored while busy=1.
  - No queuing; the latched operand is unaffected.
REQ-017 start held high continuously SHALL produce back-to-back operations, one every 35 clocks.
  - The next operation is accepted on the first IDLE edge after DONE.
REQ-018 Arithmetic SHALL be unsigned modulo 2^16, with no saturation.
  - x_in=0 gives y_out=0, ovf=0.
  - x_in=65535 gives y_out=65535, ovf=1.
REQ-019 The block SHALL NOT change y_out or ovf except on the completion edge.

Reset
REQ-020 rst=0 SHALL immediately force the following, regardless of clock:
  - state=IDLE, y_out=0, ready=0, busy=0, ovf=0;
  - multiplier accumulator, counter and operands cleared.
REQ-021 Reset mid-operation SHALL abort without a ready pulse.
  - The first start after rst returns to 1 SHALL run a full 34-clock operation.
REQ-022 No output SHALL be X after reset.

Structure
REQ-023 Package cube_pkg SHALL hold the following; all other constants SHALL be local:
  - state enum (IDLE, SQ, CU, DONE);
  - WIDTH=16, MUL_CYCLES=16, OVF_LIMIT=40.
REQ-024 The multiplier SHALL be a separate sub-module, mul_shift_add, with this interface:
  - clk, rst, start, a[15:0], b[15:0], p[31:0], done.
  - done is a one-cycle pulse in the clock after the 16th iteration.

Verification
REQ-025 After reset, start=1 with x_in=3 for one cycle -> ready pulses 34 clocks later with y_out=27, ovf=0, busy low the following cycle.
REQ-026 x_in=40 -> y_out=64000, ovf=0; x_in=41 -> y_out=3385, ovf=1; x_in=65535 -> y_out=65535, ovf=1.
REQ-027 x_in=5 accepted, then start=1 with x_in=9 at clocks 5 and 20 -> single ready pulse with y_out=125; no second operation until restarted.
REQ-028 rst driven low at clock 20 of an x_in=7 operation -> outputs zero at once, no ready pulse; then x_in=2 -> y_out=8 after 34 clocks.
REQ-029 start held high with x_in=4 -> ready pulses every 35 clocks with y_out=64; y_out and ovf stable between pulses.
